// File: rtl/snake_led_engine.sv
// snake_led_engine
//   Multi-snake LED bar animator. N_SNAKE snakes (snake i is i+1 LEDs long,
//   snake 0 leftmost) bounce off the bar ends and off each other. A single
//   free-running prescaler provides a per-snake step tick; snake i steps every
//   2^(DIV_BASE+i) enabled cycles. Everything runs on clk, no derived clocks.
//
//   Optional feature macro: SNAKE_FREEZE_EN adds a per-snake freeze input that
//   turns a snake into a static obstacle without stopping the prescaler.
//
// Ports
//   clk     in   1        system clock
//   rst     in   1        synchronous active-high reset, priority over en
//   en      in   1        run enable; 0 freezes prescaler and all snakes
//   freeze  in   N_SNAKE  (SNAKE_FREEZE_EN only) per-snake tick mask
//   led     out  LED_W    registered LED pattern
//   dir     out  N_SNAKE  registered direction per snake (1 = toward LED_W-1)
//   step    out  N_SNAKE  one-cycle pulse: snake moved
//   bump    out  N_SNAKE  one-cycle pulse: snake reversed or was fully blocked

module snake_led_engine #(
    parameter  int LED_W    = 16,
    parameter  int N_SNAKE  = 3,
    parameter  int DIV_BASE = 24,
    localparam int POS_W    = $clog2(LED_W),
    parameter  logic [N_SNAKE*POS_W-1:0] INIT_HEAD = {4'd2, 4'd11, 4'd15},
    parameter  logic [N_SNAKE-1:0]       INIT_DIR  = 3'b100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
`ifdef SNAKE_FREEZE_EN
    input  logic [N_SNAKE-1:0] freeze,
`endif
    output logic [LED_W-1:0]   led,
    output logic [N_SNAKE-1:0] dir,
    output logic [N_SNAKE-1:0] step,
    output logic [N_SNAKE-1:0] bump
);

    localparam int CNT_W = DIV_BASE + N_SNAKE - 1;

    function automatic logic [LED_W-1:0] span_mask(input int hi, input int lo);
        logic [LED_W-1:0] m;
        m = '0;
        for (int b = 0; b < LED_W; b++) begin
            m[b] = (b <= hi) && (b >= lo);
        end
        return m;
    endfunction

    function automatic logic [LED_W-1:0] init_led();
        logic [LED_W-1:0] m;
        int               h;
        m = '0;
        for (int i = 0; i < N_SNAKE; i++) begin
            h = int'(INIT_HEAD[i*POS_W +: POS_W]);
            m = m | span_mask(h, h - i);
        end
        return m;
    endfunction

    // Snakes must fit, lie inside the bar and be ordered left to right
    // without overlap; anything else is not a supported configuration.
    function automatic bit params_ok();
        int h;
        int len_sum;
        int prev_tail;
        bit ok;
        ok        = 1'b1;
        len_sum   = 0;
        prev_tail = LED_W;
        for (int i = 0; i < N_SNAKE; i++) begin
            h       = int'(INIT_HEAD[i*POS_W +: POS_W]);
            len_sum = len_sum + i + 1;
            if (h >= LED_W || h - i < 0 || h >= prev_tail) begin
                ok = 1'b0;
            end
            prev_tail = h - i;
        end
        if (len_sum > LED_W) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    localparam logic [LED_W-1:0] INIT_LED = init_led();

    if (!params_ok()) begin : g_bad_params
        $error("snake_led_engine: INIT_HEAD overlaps or snake lengths exceed LED_W");
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   head_q [N_SNAKE];
    logic [POS_W-1:0]   head_d [N_SNAKE];
    logic [N_SNAKE-1:0] dir_q, dir_d;
    logic [N_SNAKE-1:0] step_q, step_d;
    logic [N_SNAKE-1:0] bump_q, bump_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [N_SNAKE-1:0] frz;
    logic [N_SNAKE-1:0] tick;

`ifdef SNAKE_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = '0;
`endif

    // tick_i fires when the low DIV_BASE+i prescaler bits are all ones, so
    // slower snakes always tick together with every faster one.
    always_comb begin
        for (int i = 0; i < N_SNAKE; i++) begin
            tick[i] = en & ~frz[i];
            for (int b = 0; b < DIV_BASE + i; b++) begin
                tick[i] = tick[i] & cnt_q[b];
            end
        end
    end

    always_comb begin
        int   h;
        int   t;
        int   left_wall;
        int   right_wall;
        logic left_free;
        logic right_free;
        logic fwd_free;
        logic rev_free;

        cnt_d  = en ? cnt_q + CNT_W'(1) : cnt_q;
        dir_d  = dir_q;
        step_d = '0;
        bump_d = '0;
        led_d  = '0;
        h          = 0;
        t          = 0;
        right_wall = -1;
        left_free  = 1'b0;
        right_free = 1'b0;
        fwd_free   = 1'b0;
        rev_free   = 1'b0;
        for (int i = 0; i < N_SNAKE; i++) begin
            head_d[i] = head_q[i];
        end

        // left_wall carries the post-step tail of the snake to the left, so
        // in a race for one free cell the lower-index snake always wins.
        left_wall = LED_W;
        for (int i = 0; i < N_SNAKE; i++) begin
            h = int'(head_q[i]);
            t = h - i;
            right_wall = -1;
            if (i < N_SNAKE - 1) begin
                right_wall = int'(head_q[i+1]);
            end
            left_free  = (h + 1) < left_wall;
            right_free = (t - 1) > right_wall;
            fwd_free   = dir_q[i] ? left_free : right_free;
            rev_free   = dir_q[i] ? right_free : left_free;

            if (tick[i]) begin
                if (fwd_free) begin
                    h         = dir_q[i] ? h + 1 : h - 1;
                    step_d[i] = 1'b1;
                end else if (rev_free) begin
                    h         = dir_q[i] ? h - 1 : h + 1;
                    dir_d[i]  = ~dir_q[i];
                    step_d[i] = 1'b1;
                    bump_d[i] = 1'b1;
                end else begin
                    bump_d[i] = 1'b1;
                end
            end

            head_d[i] = POS_W'(h);
            led_d     = led_d | span_mask(h, h - i);
            left_wall = h - i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dir_q  <= INIT_DIR;
            step_q <= '0;
            bump_q <= '0;
            led_q  <= INIT_LED;
            for (int i = 0; i < N_SNAKE; i++) begin
                head_q[i] <= INIT_HEAD[i*POS_W +: POS_W];
            end
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            bump_q <= bump_d;
            led_q  <= led_d;
            for (int i = 0; i < N_SNAKE; i++) begin
                head_q[i] <= head_d[i];
            end
        end
    end

    assign led  = led_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign bump = bump_q;

endmodule
